// File: rtl/nn_pkg.sv
// Shared widths and state encoding for the hidden-layer neuron MAC columns.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nn_pkg;
    localparam int X_W     = 16;
    localparam int W_W     = 21;
    localparam int ADDR_W  = 9;
    localparam int ACC_W   = X_W + W_W + 9;
    localparam int N_IN_C4 = 300;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;
endpackage

// File: rtl/mac_acc.sv
// Registered signed multiplier feeding a signed accumulator, with clear and enable.
// Latency: product registered 1 cycle after en, folded into acc the cycle after.
// Backpressure: none; caller gates en and holds acc by not asserting clr.
module mac_acc
    import nn_pkg::*;
#(
    parameter int X_W   = nn_pkg::X_W,
    parameter int W_W   = nn_pkg::W_W,
    parameter int ACC_W = nn_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [X_W-1:0]   x,
    input  logic signed [W_W-1:0]   w,
    output logic signed [ACC_W-1:0] acc
);
    localparam int P_W = X_W + W_W;

    logic signed [P_W-1:0] prod;
    logic                  prod_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod   <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else if (clr) begin
            prod   <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            prod_v <= en;
            if (en)
                prod <= P_W'(x) * P_W'(w);
            if (prod_v)
                acc <= acc + ACC_W'(prod);
        end
    end
endmodule

// File: rtl/neuron_mac_c4.sv
// Column-4 dot product: streams N_IN features against weight ROM, emits the (optionally ReLU'd) sum.
// Latency: N_IN+2 cycles from start to out_valid at full input rate.
// Backpressure: x_ready only in RUN; result held in DONE until out_ready.
module neuron_mac_c4
    import nn_pkg::*;
#(
    parameter int N_IN   = N_IN_C4,
    parameter int ADDR_W = nn_pkg::ADDR_W,
    parameter int X_W    = nn_pkg::X_W,
    parameter int W_W    = nn_pkg::W_W,
    parameter int ACC_W  = nn_pkg::ACC_W,
    parameter bit RELU   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [X_W-1:0] x_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic [ADDR_W-1:0]     adrs_clm,
    input  logic signed [W_W-1:0] w_in,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    mac_state_t state, state_nx;
    logic [ADDR_W-1:0]       cnt;
    logic                    clr;
    logic                    accept;
    logic                    last;
    logic signed [ACC_W-1:0] acc;

    assign last = (cnt == ADDR_W'(N_IN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        x_ready   = 1'b0;
        out_valid = 1'b0;
        clr       = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    clr      = 1'b1;
                end
            end
            RUN: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    accept = 1'b1;
                    if (last)
                        state_nx = DRAIN;
                end
            end
            // One bubble lets the final registered product reach acc.
            DRAIN: state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // cnt doubles as the ROM address, so it parks on the last index until the result drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (accept && !last)
            cnt <= cnt + ADDR_W'(1);
        else if (state == DONE && out_ready)
            cnt <= '0;
    end

    mac_acc #(
        .X_W   (X_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (accept),
        .x     (x_data),
        .w     (w_in),
        .acc   (acc)
    );

    assign adrs_clm = cnt;
    assign busy     = (state != IDLE);
    assign out_data = (RELU && acc < 0) ? '0 : acc;
endmodule
